// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) so that one ALU, one
// register file and the memory ports are shared by every instruction.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   opcode_i, funct3_i    decoder fields, latched in DECODE
//   br_taken              branch comparator result (used in EXEC)
//   imem_ready/dmem_ready memory handshake strobes
//   state                 current state (0 IDLE .. 6 TRAP)
//   imem_req, ir_we       instruction fetch request / IR load
//   dmem_req, dmem_we,
//   dmem_size             data memory request, write, size (funct3[1:0])
//   rf_we, pc_we, pc_sel  register file write, PC update and next-PC source
//   alu_a_sel, alu_b_sel  ALU operand selects
//   wb_sel                writeback source
//   trap, trap_cause      sticky fault flag and its cause
//   instret               retired instruction counter
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       dmem_size,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] TO_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;
    localparam bit TO_EN = (TIMEOUT != 0);

    state_t           state_reg, state_next;
    logic [6:0]       op_reg, op_next;
    logic [2:0]       f3_reg, f3_next;
    logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] instret_reg, instret_next;
    logic [1:0]       cause_reg, cause_next;
    logic             retire;
    logic             timeout_hit;
    logic [1:0]       op_a_sel;
    logic             op_b_sel;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            op_reg       <= '0;
            f3_reg       <= '0;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
            cause_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            f3_reg       <= f3_next;
            wait_cnt_reg <= wait_cnt_next;
            instret_reg  <= instret_next;
            cause_reg    <= cause_next;
        end
    end

    // Operand selects depend only on the latched opcode; they are driven in
    // EXEC and held through MEM so the address stays stable during the access.
    always_comb begin
        op_a_sel = 2'd0;
        op_b_sel = 1'b0;
        case (op_reg)
            OP_I, OP_LOAD, OP_STORE, OP_JALR: op_b_sel = 1'b1;
            OP_AUIPC: begin op_a_sel = 2'd1; op_b_sel = 1'b1; end
            OP_LUI:   begin op_a_sel = 2'd2; op_b_sel = 1'b1; end
            default: ;
        endcase
    end

    assign timeout_hit = TO_EN && (wait_cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        f3_next    = f3_reg;
        cause_next = cause_reg;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_size  = 2'd0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        wb_sel     = 2'd0;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                // Ready wins over a timeout landing in the same cycle.
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = 2'd1;
                end
            end
            S_DECODE: begin
                op_next = opcode_i;
                f3_next = funct3_i;
                if (is_legal(opcode_i)) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    cause_next = 2'd3;
                end
            end
            S_EXEC: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                if (op_reg == OP_BR) begin
                    pc_we      = 1'b1;
                    pc_sel     = br_taken ? 2'd1 : 2'd0;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (op_reg == OP_LOAD || op_reg == OP_STORE) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                dmem_req  = 1'b1;
                dmem_we   = (op_reg == OP_STORE);
                dmem_size = f3_reg[1:0];
                if (dmem_ready) begin
                    if (op_reg == OP_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                    cause_next = 2'd2;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
                if (op_reg == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if (op_reg == OP_JAL || op_reg == OP_JALR) begin
                    wb_sel = 2'd2;
                end
                if (op_reg == OP_JAL) begin
                    pc_sel = 2'd1;
                end else if (op_reg == OP_JALR) begin
                    pc_sel = 2'd2;
                end
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

    // Counter restarts whenever FETCH/MEM is (re)entered; staying in either
    // state means the ready strobe was low that cycle.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (TO_EN && (state_reg == S_FETCH || state_reg == S_MEM)) begin
            wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
    end

    assign instret_next = retire ? instret_reg + CNT_W'(1) : instret_reg;

    assign state      = state_reg;
    assign trap       = (state_reg == S_TRAP);
    assign trap_cause = cause_reg;
    assign instret    = instret_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each step drives inputs, queues the expected
// output snapshot and instret, then pops and compares once outputs settle.
module tb_mc_ctrl;
    localparam int TO = 8;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Snapshot layout: {state[20:18], imem_req, ir_we, dmem_req, dmem_we,
    // dmem_size[13:12], rf_we, pc_we, pc_sel[9:8], alu_a_sel[7:6], alu_b_sel,
    // wb_sel[4:3], trap, trap_cause[1:0]}
    localparam logic [20:0] IMR = 21'h020000;
    localparam logic [20:0] IRW = 21'h010000;
    localparam logic [20:0] DRQ = 21'h008000;
    localparam logic [20:0] DWE = 21'h004000;
    localparam logic [20:0] RFW = 21'h000800;
    localparam logic [20:0] PCW = 21'h000400;
    localparam logic [20:0] ABS = 21'h000020;
    localparam logic [20:0] TRP = 21'h000004;

    function automatic logic [20:0] st(input int n);   return 21'(n) << 18; endfunction
    function automatic logic [20:0] dsz(input int n);  return 21'(n) << 12; endfunction
    function automatic logic [20:0] psel(input int n); return 21'(n) << 8;  endfunction
    function automatic logic [20:0] asel(input int n); return 21'(n) << 6;  endfunction
    function automatic logic [20:0] wsel(input int n); return 21'(n) << 3;  endfunction
    function automatic logic [20:0] cause(input int n); return 21'(n);      endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        br_taken, imem_ready, dmem_ready;
    logic [2:0]  state;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, alu_b_sel, trap;
    logic [1:0]  dmem_size, pc_sel, alu_a_sel, wb_sel, trap_cause;
    logic [31:0] instret;

    mc_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_size(dmem_size), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    wire [20:0] obs = {state, imem_req, ir_we, dmem_req, dmem_we, dmem_size,
                       rf_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, wb_sel,
                       trap, trap_cause};

    typedef struct {
        string       tag;
        logic [20:0] exp;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic step(input string tag, input bit ir, input bit dr, input bit bt,
                        input logic [20:0] e, input logic [31:0] n);
        exp_t x;
        exp_t y;
        imem_ready = ir;
        dmem_ready = dr;
        br_taken   = bt;
        x.tag = tag; x.exp = e; x.ir = n;
        sb.push_back(x);
        #1;
        y = sb.pop_front();
        checks++;
        assert (obs === y.exp) else begin
            fails++;
            $error("FAIL %s outputs: got %h expected %h", y.tag, obs, y.exp);
        end
        checks++;
        assert (instret === y.ir) else begin
            fails++;
            $error("FAIL %s instret: got %0d expected %0d", y.tag, instret, y.ir);
        end
        $display("%s: state=%0d outputs=%h instret=%0d", y.tag, state, obs, instret);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode_i = '0; funct3_i = '0;
        br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        step("reset_a", 0, 0, 0, st(0), 0);
        step("reset_b", 0, 0, 0, st(0), 0);
        rst = 1'b0;
        step("idle", 0, 0, 0, st(0), 0);

        // ADD
        opcode_i = OP_R; funct3_i = 3'd0;
        step("add_fetch",  1, 0, 0, st(1) | IMR | IRW, 0);
        step("add_decode", 0, 0, 0, st(2), 0);
        step("add_exec",   0, 0, 0, st(3), 0);
        step("add_wb",     0, 0, 0, st(5) | RFW | PCW, 0);

        // LW with three wait cycles
        opcode_i = OP_LOAD; funct3_i = 3'b010;
        step("lw_fetch",  1, 0, 0, st(1) | IMR | IRW, 1);
        step("lw_decode", 0, 0, 0, st(2), 1);
        step("lw_exec",   0, 0, 0, st(3) | ABS, 1);
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", 0, 0, 0, st(4) | DRQ | dsz(2) | ABS, 1);
        step("lw_mem_rdy", 0, 1, 0, st(4) | DRQ | dsz(2) | ABS, 1);
        step("lw_wb",      0, 0, 0, st(5) | RFW | PCW | wsel(1), 1);

        // BEQ taken, then not taken
        opcode_i = OP_BR; funct3_i = 3'd0;
        step("beq_t_fetch",  1, 0, 0, st(1) | IMR | IRW, 2);
        step("beq_t_decode", 0, 0, 0, st(2), 2);
        step("beq_t_exec",   0, 0, 1, st(3) | PCW | psel(1), 2);
        step("beq_n_fetch",  1, 0, 0, st(1) | IMR | IRW, 3);
        step("beq_n_decode", 0, 0, 0, st(2), 3);
        step("beq_n_exec",   0, 0, 0, st(3) | PCW, 3);

        // SB store, zero-wait
        opcode_i = OP_STORE; funct3_i = 3'd0;
        step("sb_fetch",  1, 0, 0, st(1) | IMR | IRW, 4);
        step("sb_decode", 0, 0, 0, st(2), 4);
        step("sb_exec",   0, 0, 0, st(3) | ABS, 4);
        step("sb_mem",    0, 1, 0, st(4) | DRQ | DWE | ABS | PCW, 4);

        // LUI
        opcode_i = OP_LUI;
        step("lui_fetch",  1, 0, 0, st(1) | IMR | IRW, 5);
        step("lui_decode", 0, 0, 0, st(2), 5);
        step("lui_exec",   0, 0, 0, st(3) | asel(2) | ABS, 5);
        step("lui_wb",     0, 0, 0, st(5) | RFW | PCW, 5);

        // JAL
        opcode_i = OP_JAL;
        step("jal_fetch",  1, 0, 0, st(1) | IMR | IRW, 6);
        step("jal_decode", 0, 0, 0, st(2), 6);
        step("jal_exec",   0, 0, 0, st(3), 6);
        step("jal_wb",     0, 0, 0, st(5) | RFW | PCW | psel(1) | wsel(2), 6);

        // JALR
        opcode_i = OP_JALR;
        step("jalr_fetch",  1, 0, 0, st(1) | IMR | IRW, 7);
        step("jalr_decode", 0, 0, 0, st(2), 7);
        step("jalr_exec",   0, 0, 0, st(3) | ABS, 7);
        step("jalr_wb",     0, 0, 0, st(5) | RFW | PCW | psel(2) | wsel(2), 7);

        // Late imem_ready on the last allowed cycle, then an illegal opcode
        opcode_i = 7'b0000000;
        for (int i = 0; i < TO - 1; i++)
            step("fetch_wait", 0, 0, 0, st(1) | IMR, 8);
        step("fetch_late_rdy", 1, 0, 0, st(1) | IMR | IRW, 8);
        step("illegal_decode", 0, 0, 0, st(2), 8);
        for (int i = 0; i < 3; i++)
            step("illegal_trap", 1, 1, 0, st(6) | TRP | cause(3), 8);

        // Reset out of TRAP
        rst = 1'b1;
        step("rst_in_trap", 0, 0, 0, st(6) | TRP | cause(3), 8);
        step("rst_cleared", 0, 0, 0, st(0), 0);
        rst = 1'b0;
        step("idle2", 0, 0, 0, st(0), 0);

        // imem timeout
        for (int i = 0; i < TO; i++)
            step("imem_to_wait", 0, 0, 0, st(1) | IMR, 0);
        for (int i = 0; i < 2; i++)
            step("imem_to_trap", 1, 0, 0, st(6) | TRP | cause(1), 0);

        rst = 1'b1;
        step("rst_in_trap2", 0, 0, 0, st(6) | TRP | cause(1), 0);
        step("rst_cleared2", 0, 0, 0, st(0), 0);
        rst = 1'b0;
        step("idle3", 0, 0, 0, st(0), 0);

        // dmem timeout on LB
        opcode_i = OP_LOAD; funct3_i = 3'd0;
        step("lb_fetch",  1, 0, 0, st(1) | IMR | IRW, 0);
        step("lb_decode", 0, 0, 0, st(2), 0);
        step("lb_exec",   0, 0, 0, st(3) | ABS, 0);
        for (int i = 0; i < TO; i++)
            step("dmem_to_wait", 0, 0, 0, st(4) | DRQ | ABS, 0);
        for (int i = 0; i < 2; i++)
            step("dmem_to_trap", 0, 1, 0, st(6) | TRP | cause(2), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
